// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - kernel weights, mode encoding, marker type and pixel helpers for sobel_stream
package sobel_pkg;

  localparam int MIN_DIM  = 3;
  localparam int W_EDGE   = 1;
  localparam int W_CENTER = 2;

  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_MAG = 1'b1
  } sobel_mode_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } sobel_mark_t;

  // Edge pixels are drawn black (all zeros), flat areas white (all ones of width dw).
  function automatic logic [31:0] bw_value(input int dw, input logic is_white);
    return is_white ? ((32'd1 << dw) - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - two-row shift line buffer, written on accept, read combinationally at the column address
module sobel_line_buf #(
  parameter int IMG_W = 100,
  parameter int DW    = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(IMG_W)-1:0] addr_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            row1_o,
  output logic [DW-1:0]            row2_o
);

  // Contents are left unreset: the first two lines of every frame overwrite them before use.
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];

  assign row1_o = lb0_q[addr_i];
  assign row2_o = lb1_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      lb0_q[addr_i] <= din_i;
      lb1_q[addr_i] <= lb0_q[addr_i];
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel |Gx|+|Gy| edge detector with frame/line markers
// Define SOBEL_MAG_EN to add the mode port and saturated magnitude output.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int DW    = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          pi_flag,
  input  logic [DW-1:0] pi_data,
  input  logic          pi_sof,
  input  logic [DW-1:0] thr,
`ifdef SOBEL_MAG_EN
  input  logic          mode,
`endif
  output logic          po_flag,
  output logic [DW-1:0] po_data,
  output logic          po_sof,
  output logic          po_eol,
  output logic          po_eof,
  output logic          err_frame
);

  localparam int MW = DW + 3;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [DW-1:0] BLACK    = DW'(bw_value(DW, 1'b0));
  localparam logic [DW-1:0] WHITE    = DW'(bw_value(DW, 1'b1));
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if (IMG_W < MIN_DIM || IMG_H < MIN_DIM) begin : g_dim_check
    $error("sobel_stream: IMG_W and IMG_H must both be at least %0d", MIN_DIM);
  end

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic [DW-1:0] lb_top, lb_mid;

  // A pixel flagged pi_sof is taken as (0,0) regardless of where the counters were.
  always_comb begin
    pos_col = pi_sof ? '0 : col_q;
    pos_row = pi_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pi_flag) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  sobel_line_buf #(
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_line_buf (
    .clk_i  (sys_clk),
    .we_i   (pi_flag),
    .addr_i (pos_col),
    .din_i  (pi_data),
    .row1_o (lb_mid),
    .row2_o (lb_top)
  );

  logic [DW-1:0] win_q [3][3];
  logic          win_vld_q, win_vld_d;
  sobel_mark_t   win_mk_q, win_mk_d;

  always_comb begin
    win_vld_d    = pi_flag && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    win_mk_d.sof = (pos_row == RW'(2)) && (pos_col == CW'(2));
    win_mk_d.eol = (pos_col == COL_LAST);
    win_mk_d.eof = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
  end

  logic [MW-1:0]        sum_l, sum_r, sum_t, sum_b;
  logic signed [MW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic                 grad_vld_q;
  sobel_mark_t          grad_mk_q;

  // Column/row sums stay below 2^(DW+2), so the signed difference never wraps.
  always_comb begin
    sum_l = MW'(W_EDGE * win_q[0][0]) + MW'(W_CENTER * win_q[1][0]) + MW'(W_EDGE * win_q[2][0]);
    sum_r = MW'(W_EDGE * win_q[0][2]) + MW'(W_CENTER * win_q[1][2]) + MW'(W_EDGE * win_q[2][2]);
    sum_t = MW'(W_EDGE * win_q[0][0]) + MW'(W_CENTER * win_q[0][1]) + MW'(W_EDGE * win_q[0][2]);
    sum_b = MW'(W_EDGE * win_q[2][0]) + MW'(W_CENTER * win_q[2][1]) + MW'(W_EDGE * win_q[2][2]);
    gx_d  = $signed(sum_r) - $signed(sum_l);
    gy_d  = $signed(sum_t) - $signed(sum_b);
  end

  logic [MW-1:0] abs_x, abs_y, mag_d, mag_q;
  logic          mag_vld_q;
  sobel_mark_t   mag_mk_q;

  always_comb begin
    abs_x = gx_q[MW-1] ? -gx_q : gx_q;
    abs_y = gy_q[MW-1] ? -gy_q : gy_q;
    mag_d = abs_x + abs_y;
  end

  logic [DW-1:0] pix_d;

  always_comb begin
    pix_d = (mag_q > MW'(thr)) ? BLACK : WHITE;
`ifdef SOBEL_MAG_EN
    if (mode == MODE_MAG) begin
      pix_d = (mag_q > MW'(WHITE)) ? WHITE : mag_q[DW-1:0];
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_q      <= '0;
      row_q      <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_vld_q  <= 1'b0;
      win_mk_q   <= '0;
      grad_vld_q <= 1'b0;
      grad_mk_q  <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      mag_vld_q  <= 1'b0;
      mag_mk_q   <= '0;
      mag_q      <= '0;
      po_flag    <= 1'b0;
      po_data    <= '0;
      po_sof     <= 1'b0;
      po_eol     <= 1'b0;
      po_eof     <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (pi_flag) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb_top;
        win_q[1][2] <= lb_mid;
        win_q[2][2] <= pi_data;
      end
      win_vld_q  <= win_vld_d;
      win_mk_q   <= win_mk_d;
      err_frame  <= pi_flag && pi_sof && ((col_q != '0) || (row_q != '0));

      // Stages past the window never stall, so gaps in pi_flag simply drain the pipe.
      grad_vld_q <= win_vld_q;
      grad_mk_q  <= win_mk_q;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      mag_vld_q  <= grad_vld_q;
      mag_mk_q   <= grad_mk_q;
      mag_q      <= mag_d;
      po_flag    <= mag_vld_q;
      po_sof     <= mag_vld_q && mag_mk_q.sof;
      po_eol     <= mag_vld_q && mag_mk_q.eol;
      po_eof     <= mag_vld_q && mag_mk_q.eof;
      if (mag_vld_q) begin
        po_data <= pix_d;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - scoreboard bench for sobel_stream (5x5, 8-bit); covers mode when SOBEL_MAG_EN is defined
module tb_sobel_stream;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          pi_flag = 1'b0;
  logic          pi_sof  = 1'b0;
  logic [DW-1:0] pi_data = '0;
  logic [DW-1:0] thr     = '0;
`ifdef SOBEL_MAG_EN
  logic          mode    = 1'b0;
`endif
  logic          po_flag, po_sof, po_eol, po_eof, err_frame;
  logic [DW-1:0] po_data;

  typedef struct {
    int data;
    bit sof;
    bit eol;
    bit eof;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   img [H][W];
  int   mcol = 0;
  int   mrow = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mag_mode = 1'b0;

  sobel_stream #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (DW)
  ) dut (
`ifdef SOBEL_MAG_EN
    .mode      (mode),
`endif
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pi_flag   (pi_flag),
    .pi_data   (pi_data),
    .pi_sof    (pi_sof),
    .thr       (thr),
    .po_flag   (po_flag),
    .po_data   (po_data),
    .po_sof    (po_sof),
    .po_eol    (po_eol),
    .po_eof    (po_eof),
    .err_frame (err_frame)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: keep the frame as an image and evaluate the Sobel formula directly.
  function automatic void model_accept(input int d, input bit sof, input int acc);
    exp_t e;
    int gx, gy, mag;
    if (sof) begin
      if (mcol != 0 || mrow != 0) err_q.push_back(acc);
      mcol = 0;
      mrow = 0;
    end
    img[mrow][mcol] = d;
    if (mrow >= 2 && mcol >= 2) begin
      gx = (img[mrow-2][mcol] + 2*img[mrow-1][mcol] + img[mrow][mcol])
         - (img[mrow-2][mcol-2] + 2*img[mrow-1][mcol-2] + img[mrow][mcol-2]);
      gy = (img[mrow-2][mcol-2] + 2*img[mrow-2][mcol-1] + img[mrow-2][mcol])
         - (img[mrow][mcol-2] + 2*img[mrow][mcol-1] + img[mrow][mcol]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag_mode) e.data = (mag > 255) ? 255 : mag;
      else          e.data = (mag > int'(thr)) ? 0 : 255;
      e.sof = (mrow == 2 && mcol == 2);
      e.eol = (mcol == W-1);
      e.eof = (mcol == W-1 && mrow == H-1);
      e.acc = acc;
      exp_q.push_back(e);
    end
    if (mcol == W-1) begin
      mcol = 0;
      mrow = (mrow == H-1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endfunction

  function automatic logic [7:0] pix(input int pat, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c < 2) ? 8'd0 : 8'd255;
      2:       return 8'(3 * c);
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  task automatic drive_px(input logic [7:0] d, input bit sof, input int gap);
    @(negedge sys_clk);
    while (gap > 0 && $urandom_range(99) < gap) begin
      pi_flag = 1'b0;
      pi_sof  = 1'b0;
      @(negedge sys_clk);
    end
    pi_flag = 1'b1;
    pi_data = d;
    pi_sof  = sof;
    model_accept(int'(d), sof, cyc + 1);
  endtask

  task automatic send_frame(input int pat, input int gap, input bit sof, input int npix);
    int pc;
    for (int i = 0; i < npix; i++) begin
      pc = (sof && i == 0) ? 0 : mcol;
      drive_px(pix(pat, pc), sof && (i == 0), gap);
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge sys_clk);
    pi_flag = 1'b0;
    pi_sof  = 1'b0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 20) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size() + err_q.size(), 0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    pi_flag = 1'b0;
    pi_sof  = 1'b0;
    sys_rst = 1'b1;
    #1;
    exp_q.delete();
    err_q.delete();
    mcol = 0;
    mrow = 0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      #1;
      chk("no_stray_po_flag", int'(po_flag), 0);
    end
  endtask

  always @(negedge sys_clk) begin : monitor
    exp_t e;
    bit   want_err;
    if (po_flag) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_po_flag", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("po_data", int'(po_data), e.data);
        chk("po_markers", int'({po_sof, po_eol, po_eof}), int'({e.sof, e.eol, e.eof}));
        chk("po_latency", cyc, e.acc + 3);
      end
    end
    want_err = (err_q.size() != 0 && err_q[0] == cyc);
    if (want_err) void'(err_q.pop_front());
    if (err_frame || want_err) chk("err_frame", int'(err_frame), int'(want_err));
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(negedge sys_clk);
    chk("rst_po_flag", int'(po_flag), 0);
    chk("rst_po_data", int'(po_data), 0);
    chk("rst_markers", int'({po_sof, po_eol, po_eof}), 0);
    chk("rst_err_frame", int'(err_frame), 0);
    sys_rst = 1'b0;

    thr = 8'd0;   send_frame(0, 0, 1'b1, 25); drain();
    thr = 8'd12;  send_frame(1, 0, 1'b1, 25); drain();
    thr = 8'd24;  send_frame(2, 0, 1'b1, 25); drain();
    thr = 8'd23;  send_frame(2, 0, 1'b1, 25); drain();

    thr = 8'($urandom_range(255));
    send_frame(3, 0, 1'b1, 25);
    send_frame(3, 0, 1'b0, 25);
    drain();

    thr = 8'd12;  send_frame(1, 50, 1'b1, 25); drain();
    thr = 8'($urandom_range(255));
    send_frame(3, 50, 1'b1, 50);
    drain();

    send_frame(3, 0, 1'b1, 7);
    send_frame(3, 0, 1'b1, 25);
    drain();
    send_frame(3, 40, 1'b0, 12);
    send_frame(3, 40, 1'b1, 25);
    drain();

    send_frame(3, 0, 1'b1, 13);
    pulse_reset();
    send_frame(3, 0, 1'b0, 25);
    drain();

`ifdef SOBEL_MAG_EN
    mode = 1'b1;
    mag_mode = 1'b1;
    send_frame(1, 0, 1'b1, 25);
    send_frame(2, 0, 1'b1, 25);
    send_frame(3, 30, 1'b1, 25);
    drain();
    mode = 1'b0;
    mag_mode = 1'b0;
`endif

    chk("final_queues_empty", exp_q.size() + err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming Sobel edge detector: the successor of the fixed 100x100, 8-bit binary detector. It accepts a raster pixel stream with arbitrary `pi_flag` gaps and holds two line buffers internally, with no FIFO IP. It computes |Gx|+|Gy| over a 3x3 window and emits one result per interior pixel, along with frame and line markers. The block sits between the pixel source (UART or camera capture) and the display/UART write-back path.

## Interface
- `IMG_W`, default 100: pixels per line; must be ≥3.
- `IMG_H`, default 100: lines per frame; must be ≥3.
- `DW`, default 8: pixel width. Magnitude width is `MW = DW+3`.
- `sys_clk`, in, 1: sole clock. All logic is on the rising edge.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `pi_flag`, in, 1: input pixel valid. A pixel is accepted on every edge where this is high.
- `pi_data`, in, DW: input pixel, unsigned.
- `pi_sof`, in, 1: qualified by `pi_flag`. Marks pixel (0,0) of a frame.
- `thr`, in, DW: runtime threshold. Sampled in the threshold stage.
- `mode`, in, 1: present only with `SOBEL_MAG_EN`. 0 = binary, 1 = magnitude.
- `po_flag`, out, 1: output pixel valid.
- `po_data`, out, DW: output pixel.
- `po_sof`, `po_eol`, `po_eof`, out, 1 each: first output of frame, last output of line, last output of frame. All are qualified by `po_flag`.
- `err_frame`, out, 1: one-cycle pulse when `pi_sof` arrives misaligned.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_W-1, IMG_H-1) both wrap to 0; the next frame may follow without `pi_sof`.
- `pi_sof` handling:
  - An accepted pixel with `pi_sof=1` is treated as (0,0), and counters load (1,0) after it.
  - If the counters were not at (0,0) at that moment, `err_frame` pulses the next cycle. No other recovery is needed.
- Line buffers `lb0` and `lb1` each have depth IMG_W, with combinational read at address `col`.
  - On accept: `lb0[col] <= pi_data`, `lb1[col] <= lb0[col]`.
  - On accept, the 3x3 window shifts left and loads the new right column {top=`lb1[col]`, mid=`lb0[col]`, bottom=`pi_data`}.
- A window is valid when the accepted pixel has row≥2 and col≥2. The output corresponds to centre (row-1, col-1).
- Gradients are signed MW-bit:
  - Gx = (right − left) column, weights 1,2,1.
  - Gy = (top − bottom) row, weights 1,2,1.
- Magnitude `mag` = |Gx|+|Gy|, unsigned MW-bit. There is no overflow by construction.
- Binary output: `mag > thr` → 0 (BLACK); otherwise all-ones (WHITE). Equality gives WHITE.
- Magnitude output (mode=1): `min(mag, 2^DW−1)`.
- Markers are carried with the valid bit through the pipeline:
  - `po_sof` for source (2,2).
  - `po_eol` for col=IMG_W-1.
  - `po_eof` for (IMG_W-1, IMG_H-1).
- There is no backpressure; the downstream must absorb one pixel per cycle.

## Timing
- Pipeline stages, for a pixel accepted at edge k:
  - Edge k: window register.
  - Edge k+1: Gx/Gy register.
  - Edge k+2: mag register.
  - Edge k+3: `po_data` and `po_flag` register.
- Latency is fixed at 3 edges after the accepting edge. Input gaps never stall stages after the window; results drain while `pi_flag` is low.
- Each frame produces (IMG_W−2)·(IMG_H−2) outputs. Back-to-back input gives back-to-back output.
- Reset values: `po_flag`, `po_sof`, `po_eol`, `po_eof`, `err_frame` = 0; `po_data` = 0.
  - Counters, window and pipeline valids clear on reset.
  - Line-buffer contents are not reset; they are unobservable because rows 0–1 refill them.
- Reset mid-frame: in-flight results are discarded and no `po_flag` follows. The next accepted pixel is (0,0).

## Configuration
- `SOBEL_MAG_EN` defined: the `mode` port exists and magnitude output is selectable.
- `SOBEL_MAG_EN` undefined: there is no `mode` port, output is binary only, and the saturation logic is absent.

## Structure
- Package `sobel_pkg` holds:
  - kernel weights;
  - mode encoding (MODE_BIN=0, MODE_MAG=1);
  - minimum-dimension constants;
  - a `black`/`white` value function of DW.
- Sub-module `sobel_line_buf`: dual-row shift line buffer (IMG_W, DW), with write-on-accept and combinational read.

## Test plan
All scenarios use IMG_W=5, IMG_H=5, DW=8 unless stated.
1. Uniform frame, all pixels 100, thr=0 → 9 outputs, all 255 (mag=0). `po_sof` on the 1st output, `po_eol` on the 3rd/6th/9th, `po_eof` on the 9th.
2. Vertical step (cols 0–1 = 0, cols 2–4 = 255), thr=12 → every row gives outputs 0, 0, 255 (mag 1020, 1020, 0).
3. Ramp pixel = 3·col (mag=24):
   - thr=24 → all 255.
   - thr=23 → all 0.
4. Scenario 2 with `pi_flag` randomly low 50% of cycles → identical data and markers. Each `po_flag` comes exactly 3 edges after its source accept.
5. `pi_sof` asserted at pixel index 7 → `err_frame` pulses once, and the next outputs align to the new (2,2). Also assert `sys_rst` mid-frame → no stray `po_flag`.
6. With `SOBEL_MAG_EN`, mode=1, Scenario 2 → outputs 255, 255, 0 (saturated). With a ramp of 3·col → all 24.
